// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus memory responder.
// Holds the responder state enum, the reset vector and bus widths.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

endpackage

// File: rtl/mips_bus_mem_array.sv
// Word RAM with per-byte write enables and a registered read port.
// Ports: clk, rd_en_i/rd_idx_i -> rdata_o; we_i/be_i/wr_idx_i/wdata_i.
module mips_bus_mem_array
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     wr_idx_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rdata_q <= mem_q[rd_idx_i];
    end
    for (int b = 0; b < BE_W; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Avalon-style memory responder: RAM window at BASE_ADDR with wait states.
// Ports: clk, reset(n), address/read/write/writedata/byteenable in;
// readdata, waitrequest, range_err, proto_err out.
// Option: RESP_RANDOM_WAIT_EN randomises wait states via a 16-bit LFSR.
module mips_bus_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = RESET_VECTOR,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
`ifdef RESP_RANDOM_WAIT_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic              range_err,
  output logic              proto_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [AW-1:0]       idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                rd_q;
  logic                wr_q;
  logic                ok_q;
  logic                range_err_q;
  logic                proto_err_q;

  logic                req;
  logic [29:0]         off_w;
  logic                in_rng;
  logic [AW-1:0]       idx_now;
  logic [4:0]          wait_n;
  logic                ram_rd_en;
  logic [AW-1:0]       ram_rd_idx;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  assign req     = read | write;
  assign off_w   = address[31:2] - BASE_W;
  assign in_rng  = (address[31:2] >= BASE_W) && (off_w < DEPTH_L);
  assign idx_now = off_w[AW-1:0];

`ifdef RESP_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign wait_n  = 5'(1 + (int'(lfsr_q[3:0]) % WAIT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == IDLE && req) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign wait_n = 5'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ok_q        <= 1'b0;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            idx_q   <= idx_now;
            wdata_q <= writedata;
            be_q    <= byteenable;
            rd_q    <= read;
            // read wins when both strobes are high
            wr_q    <= write & ~read;
            ok_q    <= in_rng;
            if (read && write) proto_err_q <= 1'b1;
            if (!in_rng) range_err_q <= 1'b1;
            if (wait_n == 5'd1) begin
              state_q <= ACK;
            end else begin
              cnt_q   <= 4'(wait_n - 5'd1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ACK;
          if (!req || address != addr_q) proto_err_q <= 1'b1;
        end
        ACK: begin
          state_q <= IDLE;
          if (!req || address != addr_q) proto_err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM word is captured on the edge that enters ACK.
  assign ram_rd_en  = (state_q == IDLE && req && wait_n == 5'd1) ||
                      (state_q == WAIT && cnt_q == 4'd1);
  assign ram_rd_idx = (state_q == IDLE) ? idx_now : idx_q;
  assign ram_we     = (state_q == ACK) && wr_q && ok_q;

  mips_bus_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk      (clk),
    .rd_en_i  (ram_rd_en),
    .rd_idx_i (ram_rd_idx),
    .rdata_o  (ram_rdata),
    .we_i     (ram_we),
    .be_i     (be_q),
    .wr_idx_i (idx_q),
    .wdata_i  (wdata_q)
  );

  assign waitrequest = req && (state_q != ACK);
  assign readdata    = (state_q == ACK && rd_q && ok_q) ? ram_rdata : '0;
  assign range_err   = range_err_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Self-checking bench for mips_bus_mem_responder.
// Random traffic checked against a word-map model of the window.
module tb_mips_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;
`ifdef RESP_RANDOM_WAIT_EN
  localparam int          WC    = 4;
`else
  localparam int          WC    = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        range_err;
  logic        proto_err;

  int errs = 0;
  int checks = 0;

  logic [31:0] mem_m [int];

  always #5 clk = ~clk;

  mips_bus_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .range_err   (range_err),
    .proto_err   (proto_err)
  );

  function automatic bit in_win(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return ((a - BASE) >> 2) < DEPTH;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int k;
    if (!in_win(a)) return 32'h0;
    k = int'((a - BASE) >> 2);
    if (mem_m.exists(k)) return mem_m[k];
    return 32'h0;
  endfunction

  function automatic void model_wr(input logic [31:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0] be);
    int k;
    logic [31:0] w;
    if (!in_win(a)) return;
    k = int'((a - BASE) >> 2);
    w = mem_m.exists(k) ? mem_m[k] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_m[k] = w;
  endfunction

  function automatic bit lat_ok(input int lat);
`ifdef RESP_RANDOM_WAIT_EN
    return lat >= 1 && lat <= WC;
`else
    return lat == WC;
`endif
  endfunction

  // Entered at posedge+1; returns at posedge+1 with the bus idle.
  task automatic xfer(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be,
                      output logic [31:0] rdat, output int lat);
    bit done = 0;
    read = rd; write = wr; address = a;
    writedata = d; byteenable = be;
    lat = 0; rdat = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rdat = readdata;
        done = 1;
        break;
      end
      lat++;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errs++;
      $display("FAIL timeout: addr %h no completion in 64 cycles", a);
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    read = 1'b0; write = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (waitrequest !== 1'b0) begin
      errs++; $display("FAIL rst_wait: got %b want 0", waitrequest);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errs++; $display("FAIL rst_rdata: got %h want 0", readdata);
    end
    checks++;
    if ({range_err, proto_err} !== 2'b00) begin
      errs++; $display("FAIL rst_err: got %b want 00", {range_err, proto_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h0 || waitrequest !== 1'b0) begin
      errs++; $display("FAIL idle_out: got %h/%b want 0/0", readdata, waitrequest);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] r;
    int lat;
    xfer(1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, r, lat);
    model_wr(32'hBFC00010, 32'hDEADBEEF, 4'hF);
    checks++;
    if (!lat_ok(lat)) begin
      errs++; $display("FAIL wr_lat: got %0d want %0d", lat, WC);
    end
    xfer(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, r, lat);
    checks++;
    if (!lat_ok(lat)) begin
      errs++; $display("FAIL rd_lat: got %0d want %0d", lat, WC);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errs++; $display("FAIL rd_data: got %h want deadbeef", r);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    int lat;
    xfer(1'b0, 1'b1, 32'hBFC00020, 32'h11223344, 4'hF, r, lat);
    model_wr(32'hBFC00020, 32'h11223344, 4'hF);
    xfer(1'b0, 1'b1, 32'hBFC00020, 32'hAABBCCDD, 4'b0101, r, lat);
    model_wr(32'hBFC00020, 32'hAABBCCDD, 4'b0101);
    xfer(1'b1, 1'b0, 32'hBFC00020, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h11BB33DD) begin
      errs++; $display("FAIL lanes: got %h want 11bb33dd", r);
    end
    xfer(1'b0, 1'b1, 32'hBFC00020, 32'hFFFFFFFF, 4'h0, r, lat);
    checks++;
    if (!lat_ok(lat)) begin
      errs++; $display("FAIL be0_lat: got %0d want %0d", lat, WC);
    end
    // low address bits are ignored
    xfer(1'b1, 1'b0, 32'hBFC00023, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== exp_rd(32'hBFC00020)) begin
      errs++; $display("FAIL be0_keep: got %h want %h", r, exp_rd(32'hBFC00020));
    end
  endtask

  task automatic test_range();
    logic [31:0] r;
    int lat;
    checks++;
    if (range_err !== 1'b0) begin
      errs++; $display("FAIL range_pre: got %b want 0", range_err);
    end
    xfer(1'b0, 1'b1, BASE, 32'h5A5A0001, 4'hF, r, lat);
    model_wr(BASE, 32'h5A5A0001, 4'hF);
    xfer(1'b1, 1'b0, 32'h00000000, 32'h0, 4'hF, r, lat);
    checks++;
    if (!lat_ok(lat) || r !== 32'h0) begin
      errs++; $display("FAIL oor_rd: got lat %0d data %h want lat %0d data 0", lat, r, WC);
    end
    checks++;
    if (range_err !== 1'b1) begin
      errs++; $display("FAIL range_set: got %b want 1", range_err);
    end
    // first word past the window must not alias onto word 0
    xfer(1'b0, 1'b1, BASE + 32'(DEPTH * 4), 32'hBAD0BAD0, 4'hF, r, lat);
    xfer(1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errs++; $display("FAIL oor_top: got %h want 0", r);
    end
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== exp_rd(BASE)) begin
      errs++; $display("FAIL oor_alias: got %h want %h", r, exp_rd(BASE));
    end
    checks++;
    if (range_err !== 1'b1) begin
      errs++; $display("FAIL range_sticky: got %b want 1", range_err);
    end
  endtask

  task automatic test_rw_together();
    logic [31:0] r;
    int lat;
    checks++;
    if (proto_err !== 1'b0) begin
      errs++; $display("FAIL proto_pre: got %b want 0", proto_err);
    end
    xfer(1'b1, 1'b1, 32'hBFC00010, 32'h12345678, 4'hF, r, lat);
    checks++;
    if (r !== exp_rd(32'hBFC00010)) begin
      errs++; $display("FAIL rw_data: got %h want %h", r, exp_rd(32'hBFC00010));
    end
    checks++;
    if (proto_err !== 1'b1) begin
      errs++; $display("FAIL rw_proto: got %b want 1", proto_err);
    end
    xfer(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== exp_rd(32'hBFC00010)) begin
      errs++; $display("FAIL rw_ram: got %h want %h", r, exp_rd(32'hBFC00010));
    end
  endtask

  task automatic test_drop();
    logic [31:0] r;
    int lat;
    do_reset();
    checks++;
    if ({range_err, proto_err} !== 2'b00) begin
      errs++; $display("FAIL drop_clr: got %b want 00", {range_err, proto_err});
    end
    read = 1'b1; address = 32'hBFC00020; byteenable = 4'hF;
    @(posedge clk); #1;
    read = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (proto_err !== 1'b1) begin
      errs++; $display("FAIL drop_proto: got %b want 1", proto_err);
    end
    xfer(1'b1, 1'b0, 32'hBFC00020, 32'h0, 4'hF, r, lat);
    checks++;
    if (!lat_ok(lat) || r !== exp_rd(32'hBFC00020)) begin
      errs++; $display("FAIL drop_after: got lat %0d data %h want lat %0d data %h",
                       lat, r, WC, exp_rd(32'hBFC00020));
    end
    checks++;
    if (proto_err !== 1'b1) begin
      errs++; $display("FAIL drop_sticky: got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    xfer(1'b0, 1'b1, 32'hBFC00004, 32'hCAFEF00D, 4'hF, r, lat);
    model_wr(32'hBFC00004, 32'hCAFEF00D, 4'hF);
    write = 1'b1; address = 32'hBFC00004;
    writedata = 32'h0BADF00D; byteenable = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0; write = 1'b0;
    #1;
    checks++;
    if (waitrequest !== 1'b0 || readdata !== 32'h0) begin
      errs++; $display("FAIL mid_rst: got %b/%h want 0/0", waitrequest, readdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, r, lat);
    checks++;
    if (!lat_ok(lat) || r !== 32'hCAFEF00D) begin
      errs++; $display("FAIL mid_keep: got lat %0d data %h want lat %0d data cafef00d",
                       lat, r, WC);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, d;
    logic [3:0]  be;
    int lat;
    int idxs[32];
    int hist[16];
    for (int i = 0; i < 16; i++) hist[i] = 0;
    for (int i = 0; i < 32; i++) begin
      idxs[i] = int'($urandom_range(DEPTH - 1, 0));
      a = BASE + 32'(idxs[i] * 4);
      d = $urandom;
      xfer(1'b0, 1'b1, a, d, 4'hF, r, lat);
      model_wr(a, d, 4'hF);
      if (lat >= 0 && lat < 16) hist[lat]++;
    end
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'(idxs[$urandom_range(31, 0)] * 4);
      d = $urandom;
      be = 4'($urandom);
      xfer(1'b0, 1'b1, a, d, be, r, lat);
      model_wr(a, d, be);
      if (lat >= 0 && lat < 16) hist[lat]++;
    end
    for (int i = 0; i < 100; i++) begin
      a = BASE + 32'(idxs[$urandom_range(31, 0)] * 4);
      xfer(1'b1, 1'b0, a, 32'h0, 4'hF, r, lat);
      if (lat >= 0 && lat < 16) hist[lat]++;
      checks++;
      if (!lat_ok(lat) || r !== exp_rd(a)) begin
        errs++; $display("FAIL rnd_rd: addr %h got lat %0d data %h want lat %0d data %h",
                         a, lat, r, WC, exp_rd(a));
      end
    end
`ifdef RESP_RANDOM_WAIT_EN
    for (int v = 1; v <= WC; v++) begin
      checks++;
      if (hist[v] == 0) begin
        errs++; $display("FAIL rnd_hist: latency %0d seen 0 times want >0", v);
      end
    end
`else
    checks++;
    if (hist[WC] != 148) begin
      errs++; $display("FAIL rnd_hist: got %0d fixed-latency xfers want 148", hist[WC]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_range();
    test_rw_together();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
